// File: rtl/ppg_afe_pkg.sv
// Shared state encoding, default thresholds and width helper for the PPG AFE controller.
package ppg_afe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DC_SETTLE,
    DC_MEAS,
    DC_EVAL,
    PGA_SETTLE,
    PGA_MEAS,
    PGA_EVAL,
    OPERATE
  } afe_state_t;

  localparam int DEF_TGT_LO   = 120;
  localparam int DEF_TGT_HI   = 130;
  localparam int DEF_CLIP_LO  = 10;
  localparam int DEF_CLIP_HI  = 245;
  localparam int DEF_MAX_ITER = 64;

  // Channel index width, never below one bit so a single-channel build still has a port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ppg_window_stats.sv
// Min/max of WIN consecutive ADC samples; start re-arms the window and clears done.
module ppg_window_stats
  import ppg_afe_pkg::*;
#(
  parameter int ADC_W = 8,
  parameter int WIN   = 16
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADC_W-1:0] adc,
  output logic [ADC_W-1:0] vmin,
  output logic [ADC_W-1:0] vmax,
  output logic             done
);

  localparam int CNT_W = $clog2(WIN + 1);

  logic [CNT_W-1:0] cnt;
  logic             active;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      vmin   <= '1;
      vmax   <= '0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else if (start) begin
      vmin   <= '1;
      vmax   <= '0;
      cnt    <= CNT_W'(WIN);
      active <= 1'b1;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (active) begin
        if (adc < vmin) vmin <= adc;
        if (adc > vmax) vmax <= adc;
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ppg_afe_ctrl.sv
// PPG AFE controller: per-channel DC/PGA calibration, then round-robin LED sampling.
// Define CAL_TIMEOUT_EN to bound the DC search to MAX_ITER steps per channel.
//  state      | meaning
//  IDLE       | LEDs off, waiting for Find_setting
//  DC_SETTLE  | LED on, discard samples after a DC change
//  DC_MEAS    | min/max window for the DC search
//  DC_EVAL    | step the DC code or lock it
//  PGA_SETTLE | discard samples after a gain change
//  PGA_MEAS   | min/max window for the clip check
//  PGA_EVAL   | raise gain or lock it, advance channel
//  OPERATE    | round-robin slots, one sample per slot
module ppg_afe_ctrl
  import ppg_afe_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int ADC_W    = 8,
  parameter int DC_W     = 7,
  parameter int PGA_W    = 4,
  parameter int WIN      = 16,
  parameter int SETTLE   = 3,
  parameter int SLOT     = 10,
  parameter int TGT_LO   = DEF_TGT_LO,
  parameter int TGT_HI   = DEF_TGT_HI,
  parameter int CLIP_LO  = DEF_CLIP_LO,
  parameter int CLIP_HI  = DEF_CLIP_HI,
  parameter int MAX_ITER = DEF_MAX_ITER
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic [ADC_W-1:0]             ADC,
  input  logic                         Find_setting,
  output logic [NCH-1:0]               LED_EN,
  output logic [DC_W-1:0]              DC_Comp,
  output logic [PGA_W-1:0]             PGA_Gain,
  output logic                         CLK_Filter,
  output logic                         cal_busy,
  output logic                         cal_done,
  output logic [NCH-1:0]               cal_fail,
  output logic                         sample_valid,
  output logic [clog2_min1(NCH)-1:0]   sample_ch,
  output logic [ADC_W-1:0]             sample_data
);

  localparam int CH_W  = clog2_min1(NCH);
  localparam int TMR_W = $clog2(SLOT);

  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NCH - 1);
  localparam logic [TMR_W-1:0] SET_LD  = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] SLOT_LD = TMR_W'(SLOT - 1);
  localparam logic [ADC_W-1:0] TLO     = ADC_W'(TGT_LO);
  localparam logic [ADC_W-1:0] THI     = ADC_W'(TGT_HI);
  localparam logic [ADC_W-1:0] CLO     = ADC_W'(CLIP_LO);
  localparam logic [ADC_W-1:0] CHI     = ADC_W'(CLIP_HI);

  afe_state_t       state, state_nxt;
  logic [CH_W-1:0]  ch, ch_nxt, slot_ch, slot_ch_nxt;
  logic [DC_W-1:0]  dc_comp, dc_nxt;
  logic [PGA_W-1:0] pga_gain, pga_nxt, pga_lock;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [NCH-1:0]   fail_nxt;
  logic             busy_nxt, done_nxt, smp_nxt;
  logic             dc_we, pga_we, dc_step, win_start, it_exp;

  logic [DC_W-1:0]  dc_mem  [NCH];
  logic [PGA_W-1:0] pga_mem [NCH];

  logic [ADC_W-1:0] vmin, vmax, avg;
  logic             win_done, low, high, clip;

  ppg_window_stats #(.ADC_W(ADC_W), .WIN(WIN)) u_stats (
    .CLK   (CLK),
    .rst_n (rst_n),
    .start (win_start),
    .adc   (ADC),
    .vmin  (vmin),
    .vmax  (vmax),
    .done  (win_done)
  );

  // Sum carried at ADC_W+1 bits so the midpoint never overflows.
  assign avg  = ADC_W'(({1'b0, vmax} + {1'b0, vmin}) >> 1);
  assign low  = (avg < TLO);
  assign high = (avg > THI);
  assign clip = (vmin < CLO) || (vmax > CHI);

`ifdef CAL_TIMEOUT_EN
  localparam int              IT_W  = $clog2(MAX_ITER + 1);
  localparam logic [IT_W-1:0] IT_LD = IT_W'(MAX_ITER);
  logic [IT_W-1:0] iter_left;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)                                           iter_left <= IT_LD;
    else if (Find_setting)                                iter_left <= IT_LD;
    else if (dc_step)                                     iter_left <= iter_left - 1'b1;
    else if (!(state inside {DC_SETTLE, DC_MEAS, DC_EVAL})) iter_left <= IT_LD;
  end

  assign it_exp = (iter_left == '0);
`else
  logic unused_max_iter;
  assign unused_max_iter = (MAX_ITER != 0) ^ dc_step;
  assign it_exp = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    ch_nxt      = ch;
    slot_ch_nxt = slot_ch;
    dc_nxt      = dc_comp;
    pga_nxt     = pga_gain;
    tmr_nxt     = (tmr != '0) ? tmr - 1'b1 : tmr;
    fail_nxt    = cal_fail;
    busy_nxt    = cal_busy;
    done_nxt    = cal_done;
    smp_nxt     = 1'b0;
    dc_we       = 1'b0;
    pga_we      = 1'b0;
    dc_step     = 1'b0;
    win_start   = 1'b0;
    pga_lock    = pga_gain;
    if (Find_setting) begin
      state_nxt = DC_SETTLE;
      ch_nxt    = '0;
      dc_nxt    = '0;
      pga_nxt   = '0;
      fail_nxt  = '0;
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
      tmr_nxt   = SET_LD;
    end else begin
      case (state)
        IDLE: ;
        DC_SETTLE, PGA_SETTLE: begin
          if (tmr == '0) begin
            state_nxt = (state == DC_SETTLE) ? DC_MEAS : PGA_MEAS;
            win_start = 1'b1;
          end
        end
        DC_MEAS:  if (win_done) state_nxt = DC_EVAL;
        PGA_MEAS: if (win_done) state_nxt = PGA_EVAL;
        DC_EVAL: begin
          if (!low && !high || it_exp || (low && dc_comp == '0) || (high && dc_comp == '1)) begin
            if (low || high) fail_nxt[ch] = 1'b1;
            dc_we     = 1'b1;
            pga_nxt   = '0;
            state_nxt = PGA_SETTLE;
          end else begin
            dc_nxt    = low ? dc_comp - 1'b1 : dc_comp + 1'b1;
            dc_step   = 1'b1;
            state_nxt = DC_SETTLE;
          end
          tmr_nxt = SET_LD;
        end
        PGA_EVAL: begin
          tmr_nxt = SET_LD;
          if (clip || pga_gain == '1) begin
            pga_we   = 1'b1;
            pga_lock = clip ? ((pga_gain == '0) ? '0 : pga_gain - 1'b1) : pga_gain;
            dc_nxt   = '0;
            pga_nxt  = '0;
            if (ch == CH_LAST) begin
              state_nxt   = OPERATE;
              busy_nxt    = 1'b0;
              done_nxt    = 1'b1;
              slot_ch_nxt = '0;
              tmr_nxt     = SLOT_LD;
            end else begin
              ch_nxt    = ch + 1'b1;
              state_nxt = DC_SETTLE;
            end
          end else begin
            pga_nxt   = pga_gain + 1'b1;
            state_nxt = PGA_SETTLE;
          end
        end
        OPERATE: begin
          if (tmr == '0) begin
            smp_nxt     = 1'b1;
            tmr_nxt     = SLOT_LD;
            slot_ch_nxt = (slot_ch == CH_LAST) ? '0 : slot_ch + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ch           <= '0;
      slot_ch      <= '0;
      dc_comp      <= '0;
      pga_gain     <= '0;
      tmr          <= '0;
      cal_fail     <= '0;
      cal_busy     <= 1'b0;
      cal_done     <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      CLK_Filter   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        dc_mem[i]  <= '0;
        pga_mem[i] <= '0;
      end
    end else begin
      state        <= state_nxt;
      ch           <= ch_nxt;
      slot_ch      <= slot_ch_nxt;
      dc_comp      <= dc_nxt;
      pga_gain     <= pga_nxt;
      tmr          <= tmr_nxt;
      cal_fail     <= fail_nxt;
      cal_busy     <= busy_nxt;
      cal_done     <= done_nxt;
      sample_valid <= smp_nxt;
      CLK_Filter   <= ~CLK_Filter;
      if (smp_nxt) begin
        sample_ch   <= slot_ch;
        sample_data <= ADC;
      end
      if (dc_we)  dc_mem[ch]  <= dc_comp;
      if (pga_we) pga_mem[ch] <= pga_lock;
    end
  end

  // In OPERATE the pins follow the slot's stored settings from the first cycle of the slot.
  always_comb begin
    LED_EN   = '0;
    DC_Comp  = dc_comp;
    PGA_Gain = pga_gain;
    if (state == OPERATE) begin
      LED_EN[slot_ch] = 1'b1;
      DC_Comp         = dc_mem[slot_ch];
      PGA_Gain        = pga_mem[slot_ch];
    end else if (state != IDLE) begin
      LED_EN[ch] = 1'b1;
    end
  end

endmodule
